// File: rtl/data_bram_pkg.sv
// Shared constants and FSM state type for the data_bram block.
package data_bram_pkg;

   localparam int DEPTH_DEF = 256;
   localparam int AW_DEF    = 8;
   localparam int DATA_W    = 32;
   localparam int LANE_W    = 8;
   localparam int NLANES    = DATA_W / LANE_W;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOST  = 2'd2
   } state_t;

endpackage

// File: rtl/data_bram_if.sv
// Host request/response channel of data_bram; master drives requests, slave is the memory.
interface data_bram_if #(
   parameter int AW = data_bram_pkg::AW_DEF
);
   logic                            HOST_VALID;
   logic                            HOST_READY;
   logic                            HOST_WE;
   logic [AW-1:0]                   HOST_ADDR;
   logic [data_bram_pkg::DATA_W-1:0] HOST_WDATA;
   logic                            HOST_RVALID;
   logic [data_bram_pkg::DATA_W-1:0] HOST_RDATA;

   modport master (
      output HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
      input  HOST_READY, HOST_RVALID, HOST_RDATA
   );

   modport slave (
      input  HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
      output HOST_READY, HOST_RVALID, HOST_RDATA
   );
endinterface

// File: rtl/data_bram_bank.sv
// Single-port word RAM with byte-lane write enables, read-first, one-cycle registered read.
module bram_bank
   import data_bram_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic [NLANES-1:0] we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] dout_q;

   // Contents are never reset; the read register samples the old word before the write lands.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         dout_q <= mem_q[addr_i];
         for (int i = 0; i < NLANES; i++) begin
            if (we_i[i]) mem_q[addr_i][i*LANE_W +: LANE_W] <= din_i[i*LANE_W +: LANE_W];
         end
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/data_bram.sv
// Dual-owner data RAM: zero-fills itself, then serves either the fetch port or the host channel.
// Optional macro DATA_BRAM_OUTREG_EN adds an output register (read latency 2 instead of 1).
module data_bram
   import data_bram_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       addrb,
   input  logic [31:0]       dinb,
   output logic [31:0]       doutb,
   input  logic              enb,
   input  logic [NLANES-1:0] web,
   input  logic              HOST_MODE,
   data_bram_if.slave        host,
   output logic              MEM_READY,
   output logic              ADDR_ERR
);

   state_t            st_q;
   logic [AW-1:0]     init_cnt_q;
   logic              mem_ready_q;
   logic              host_ready_q;
   logic              addr_err_q;
   logic              fetch_hit_q;
   logic              fetch_clr_q;
   logic              host_rd_q;
   logic [DATA_W-1:0] doutb_hold_q;
   logic [DATA_W-1:0] rdata_hold_q;

   logic              addr_oor;
   logic              fetch_acc;
   logic              host_acc;
   logic [DATA_W-1:0] doutb_d;
   logic [DATA_W-1:0] rdata_d;

   logic              bk_en;
   logic [NLANES-1:0] bk_we;
   logic [AW-1:0]     bk_addr;
   logic [DATA_W-1:0] bk_din;
   logic [DATA_W-1:0] bk_dout;

   assign addr_oor  = |addrb[31:AW];
   assign fetch_acc = (st_q == ST_FETCH) && enb && !addr_oor;
   assign host_acc  = (st_q == ST_HOST) && host.HOST_VALID;

   always_ff @(posedge CLK) begin
      if (RST) begin
         st_q         <= ST_INIT;
         init_cnt_q   <= '0;
         mem_ready_q  <= 1'b0;
         host_ready_q <= 1'b0;
      end else begin
         unique case (st_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + AW'(1);
               if (init_cnt_q == AW'(DEPTH - 1)) begin
                  mem_ready_q <= 1'b1;
                  if (HOST_MODE) begin
                     st_q         <= ST_HOST;
                     host_ready_q <= 1'b1;
                  end else begin
                     st_q <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (HOST_MODE) begin
                  st_q         <= ST_HOST;
                  host_ready_q <= 1'b1;
               end
            end
            ST_HOST: begin
               if (!HOST_MODE) begin
                  st_q         <= ST_FETCH;
                  host_ready_q <= 1'b0;
               end
            end
            default: begin
               st_q         <= ST_INIT;
               init_cnt_q   <= '0;
               mem_ready_q  <= 1'b0;
               host_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // The owner of the current state is the only agent reaching the bank.
   always_comb begin
      bk_en   = 1'b0;
      bk_we   = '0;
      bk_addr = init_cnt_q;
      bk_din  = '0;
      unique case (st_q)
         ST_INIT: begin
            bk_en = 1'b1;
            bk_we = '1;
         end
         ST_FETCH: begin
            bk_en   = fetch_acc;
            bk_we   = web;
            bk_addr = addrb[AW-1:0];
            bk_din  = dinb;
         end
         ST_HOST: begin
            bk_en   = host_acc;
            bk_we   = {NLANES{host.HOST_WE}};
            bk_addr = host.HOST_ADDR;
            bk_din  = host.HOST_WDATA;
         end
         default: ;
      endcase
   end

   bram_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk_i  (CLK),
      .en_i   (bk_en),
      .we_i   (bk_we),
      .addr_i (bk_addr),
      .din_i  (bk_din),
      .dout_o (bk_dout)
   );

   // Bank output is shared, so each side keeps its own held copy of the last result.
   assign doutb_d = fetch_hit_q ? bk_dout : (fetch_clr_q ? '0 : doutb_hold_q);
   assign rdata_d = host_rd_q ? bk_dout : rdata_hold_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_hit_q  <= 1'b0;
         fetch_clr_q  <= 1'b0;
         host_rd_q    <= 1'b0;
         addr_err_q   <= 1'b0;
         doutb_hold_q <= '0;
         rdata_hold_q <= '0;
      end else begin
         fetch_hit_q  <= fetch_acc;
         fetch_clr_q  <= (st_q != ST_FETCH) || (enb && addr_oor);
         host_rd_q    <= host_acc && !host.HOST_WE;
         addr_err_q   <= addr_err_q || (enb && addr_oor);
         doutb_hold_q <= doutb_d;
         rdata_hold_q <= rdata_d;
      end
   end

`ifdef DATA_BRAM_OUTREG_EN
   logic [DATA_W-1:0] doutb_p1_q;
   logic [DATA_W-1:0] rdata_p1_q;
   logic              rvalid_p1_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         doutb_p1_q  <= '0;
         rdata_p1_q  <= '0;
         rvalid_p1_q <= 1'b0;
      end else begin
         doutb_p1_q  <= doutb_d;
         rdata_p1_q  <= rdata_d;
         rvalid_p1_q <= host_rd_q;
      end
   end

   assign doutb            = doutb_p1_q;
   assign host.HOST_RDATA  = rdata_p1_q;
   assign host.HOST_RVALID = rvalid_p1_q;
`else
   assign doutb            = doutb_d;
   assign host.HOST_RDATA  = rdata_d;
   assign host.HOST_RVALID = host_rd_q;
`endif

   assign host.HOST_READY = host_ready_q;
   assign MEM_READY       = mem_ready_q;
   assign ADDR_ERR        = addr_err_q;

endmodule

// File: doc/data_bram.md
DATA_BRAM -- requirements
Module: data_bram

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 8, word address width; DEPTH equals 2**AW.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port addrb  in  32  fetch-side word address.
REQ-006 SHALL have port dinb  in  32  fetch-side write data.
REQ-007 SHALL have port doutb  out  32  fetch-side read data.
REQ-008 SHALL have port enb  in  1  fetch-side access enable.
REQ-009 SHALL have port web  in  4  fetch-side byte-lane write enables; bit i controls bits 8i+7:8i.
REQ-010 SHALL have port HOST_MODE  in  1  1 gives memory ownership to host port, 0 to fetch port.
REQ-011 SHALL have ports HOST_VALID in 1, HOST_READY out 1, HOST_WE in 1, HOST_ADDR in AW, HOST_WDATA in 32: host request channel.
REQ-012 SHALL have ports HOST_RVALID out 1, HOST_RDATA out 32: host read response.
REQ-013 SHALL have ports MEM_READY out 1 (init complete) and ADDR_ERR out 1 (sticky out-of-range flag).

Function
REQ-014 SHALL implement FSM states INIT, FETCH, HOST.
REQ-015 INIT SHALL write zero to one word per cycle, addresses 0..DEPTH-1 ascending, then go to HOST if HOST_MODE=1 else FETCH; duration exactly DEPTH cycles.
REQ-016 MEM_READY SHALL be 0 in INIT and 1 from the first cycle in FETCH or HOST.
REQ-017 FETCH SHALL go to HOST when HOST_MODE=1 is sampled; HOST SHALL go to FETCH when HOST_MODE=0 is sampled; switch takes effect next cycle.
REQ-018 In FETCH with enb=1, a read of addrb SHALL present the word on doutb one cycle later; doutb SHALL hold its value when enb=0.
REQ-019 In FETCH with enb=1, each lane i with web[i]=1 SHALL write dinb lane i; unset lanes unchanged.
REQ-020 Read and write to the same address in one cycle SHALL return the old data (read-first).
REQ-021 If addrb[31:AW] is nonzero with enb=1: write dropped, doutb returns 0 next cycle, ADDR_ERR set to 1 and held until reset.
REQ-022 Outside FETCH, fetch-side writes SHALL be dropped and doutb SHALL read 0.
REQ-023 HOST_READY SHALL be 1 only in HOST; a request is accepted on HOST_VALID&HOST_READY.
REQ-024 Accepted host write (HOST_WE=1) SHALL write all four lanes of HOST_WDATA.
REQ-025 Accepted host read SHALL pulse HOST_RVALID for exactly one cycle, the cycle after acceptance, with HOST_RDATA valid then; HOST_RDATA holds otherwise.
REQ-026 A host read accepted in the last HOST cycle SHALL still produce its HOST_RVALID after switching to FETCH.
REQ-027 Host one request per cycle, back-to-back allowed, no stall in HOST.

Reset
REQ-028 RST=1 SHALL force state INIT, init counter 0, doutb 0, HOST_READY 0, HOST_RVALID 0, HOST_RDATA 0, MEM_READY 0, ADDR_ERR 0.
REQ-029 RST asserted mid-INIT or mid-transaction SHALL abandon it and restart INIT from address 0 after release.

Configuration
REQ-030 Macro DATA_BRAM_OUTREG_EN defined SHALL add one output register to doutb and HOST_RDATA/HOST_RVALID, making read latency 2 cycles; undefined latency is 1 cycle per REQ-018/025.
REQ-031 With DATA_BRAM_OUTREG_EN the extra register SHALL reset to 0 and write behaviour SHALL be unchanged.

Structure
REQ-032 Package data_bram_pkg SHALL hold DEPTH/AW defaults, the FSM state enum, and lane-width constant (8).
REQ-033 Storage SHALL be sub-module bram_bank: single-port, byte-lane write enables, read-first, 1-cycle read, no reset of contents.

Verification
REQ-034 Reset release, HOST_MODE=0 -> MEM_READY rises after exactly 256 cycles; fetch read addr 5 returns 0.
REQ-035 FETCH: write addrb=3, dinb=0xDEADBEEF, web=4'b0111, then read 3 -> doutb=0x00ADBEEF one cycle later.
REQ-036 FETCH: same-cycle write 0x11111111 and read at addr 7 holding 0x22222222 -> doutb=0x22222222, next read 0x11111111.
REQ-037 FETCH: read addrb=0x100 -> doutb=0 next cycle, ADDR_ERR=1 and stays 1 across later valid accesses.
REQ-038 HOST: write addr 9 = 0xCAFEF00D, then read 9 -> HOST_RVALID one-cycle pulse, HOST_RDATA=0xCAFEF00D; switch to FETCH, read addrb=9 -> 0xCAFEF00D.
REQ-039 RST asserted at INIT cycle 100 -> MEM_READY stays 0 for full 256 cycles after release; repeat REQ-035 with DATA_BRAM_OUTREG_EN -> data two cycles later.
